// File: rtl/store_monitor.sv
// Data-memory write-bus monitor: classifies stores against pass/scratch
// addresses, latches a sticky verdict and accumulates an execution signature.
module store_monitor #(
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd25,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter logic [31:0] TIMEOUT     = 32'd10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [31:0] Instr,
  input  logic [31:0] PC,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] hash,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count,
  output logic [31:0] fail_adr,
  output logic [31:0] fail_data
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2,
    S_TOUT = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic [31:0] r_hash;
  logic [15:0] r_store_count;
  logic [31:0] r_cycle_count;
  logic [31:0] r_fail_adr;
  logic [31:0] r_fail_data;

  logic [31:0] w_h;
  logic [31:0] w_hash_next;
  logic        w_pass_store;
  logic        w_fail_store;
  logic        w_scratch_store;
  logic        w_last_cycle;

  // Signature: fold the sampled bus into the hash, then rotate through an LFSR tap.
  always_comb begin
    w_h         = r_hash ^ Instr ^ PC ^ (MemWrite ? WriteData : '0);
    w_hash_next = {w_h[30:0], w_h[9] ^ w_h[29] ^ w_h[30] ^ w_h[31]};
  end

  always_comb begin
    w_pass_store    = MemWrite && (DataAdr == PASS_ADR) && (WriteData == PASS_DATA);
    w_fail_store    = MemWrite && !w_pass_store && (DataAdr != SCRATCH_ADR);
    w_scratch_store = MemWrite && !w_pass_store && !w_fail_store;
    w_last_cycle    = (r_cycle_count == (TIMEOUT - 32'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_hash        <= '0;
      r_store_count <= '0;
      r_cycle_count <= '0;
      r_fail_adr    <= '0;
      r_fail_data   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_hash        <= w_hash_next;
          r_cycle_count <= r_cycle_count + 32'd1;
          if (w_pass_store) begin
            r_state <= S_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_fail_store) begin
            r_state     <= S_FAIL;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_adr  <= DataAdr;
            r_fail_data <= WriteData;
          end else begin
            // A scratch store on the final cycle still counts before the timeout lands.
            if (w_scratch_store && (r_store_count != 16'hFFFF))
              r_store_count <= r_store_count + 16'd1;
            if (w_last_cycle) begin
              r_state   <= S_TOUT;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign hash        = r_hash;
  assign store_count = r_store_count;
  assign cycle_count = r_cycle_count;
  assign fail_adr    = r_fail_adr;
  assign fail_data   = r_fail_data;

endmodule

// File: tb/tb_store_monitor.sv
// Directed vector bench for store_monitor: a short-timeout instance for verdicts
// and hashing, a long-timeout instance for store-count saturation.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData, Instr, PC;

  logic        a_done, a_pass, a_fail, a_tout;
  logic [31:0] a_hash, a_cc, a_fa, a_fd;
  logic [15:0] a_sc;
  logic        b_done, b_pass, b_fail, b_tout;
  logic [31:0] b_hash, b_cc, b_fa, b_fd;
  logic [15:0] b_sc;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  store_monitor #(.PASS_ADR(32'd100), .PASS_DATA(32'd25), .SCRATCH_ADR(32'd96), .TIMEOUT(32'd8)) dut_a (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .Instr(Instr), .PC(PC), .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tout),
    .hash(a_hash), .store_count(a_sc), .cycle_count(a_cc), .fail_adr(a_fa), .fail_data(a_fd));

  store_monitor #(.PASS_ADR(32'd100), .PASS_DATA(32'd25), .SCRATCH_ADR(32'd96), .TIMEOUT(32'd100000)) dut_b (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .Instr(Instr), .PC(PC), .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_tout),
    .hash(b_hash), .store_count(b_sc), .cycle_count(b_cc), .fail_adr(b_fa), .fail_data(b_fd));

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [3:0]  flags;   // {done, pass, fail, timeout}
    logic [15:0] sc;
    logic [31:0] cc;
    logic [31:0] fa;
    logic [31:0] fd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_hash(input logic [31:0] h0, input logic [31:0] ins,
                                           input logic [31:0] pc, input logic we, input logic [31:0] wd);
    logic [31:0] h;
    h = h0 ^ ins ^ pc ^ (we ? wd : 32'd0);
    return {h[30:0], h[9] ^ h[29] ^ h[30] ^ h[31]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [3:0] flags, input logic [15:0] sc, input logic [31:0] cc,
                              input logic [31:0] fa, input logic [31:0] fd);
    vec_t v;
    v.rst = rst; v.we = we; v.adr = adr; v.dat = dat; v.ins = ins; v.pc = pc;
    v.flags = flags; v.sc = sc; v.cc = cc; v.fa = fa; v.fd = fd;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [31:0] ins, input logic [31:0] pc);
    reset = rst; MemWrite = we; DataAdr = adr; WriteData = dat; Instr = ins; PC = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] m_hash;
    logic        m_live;
    localparam logic [3:0] F_NONE = 4'b0000, F_PASS = 4'b1100, F_FAIL = 4'b1010, F_TOUT = 4'b1001;

    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; Instr = '0; PC = '0;

    // Pass path: scratch store then the pass store
    vecs.push_back(mk(1, 0, 0,   0,  0, 0, F_NONE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 96,  7,  0, 0, F_NONE, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 100, 25, 0, 0, F_PASS, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 104, 1,  0, 0, F_PASS, 1, 2, 0, 0));
    // Reset beats a store on the same edge; wrong data to the pass address fails
    vecs.push_back(mk(1, 1, 100, 24, 0, 0, F_NONE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 100, 24, 0, 0, F_FAIL, 0, 1, 100, 24));
    vecs.push_back(mk(0, 1, 100, 25, 0, 0, F_FAIL, 0, 1, 100, 24));
    vecs.push_back(mk(0, 1, 104, 32'hDEADBEEF, 0, 0, F_FAIL, 0, 1, 100, 24));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 104, 32'hDEADBEEF, 32'h13, 32'h4, F_FAIL, 0, 1, 104, 32'hDEADBEEF));
    // Hash from zero, then a mid-run reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00500113, 0, F_NONE, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 96, 32'hA5A5A5A5, 32'h12345678, 32'h80, F_NONE, 1, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0, 0));
    // Timeout after the 8th edge, then frozen
    for (int unsigned k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 0, 0, k * 32'h11, k * 4, (k == 8) ? F_TOUT : F_NONE, 0, k, 0, 0));
    vecs.push_back(mk(0, 1, 100, 25, 32'h99, 32'h40, F_TOUT, 0, 8, 0, 0));
    // Pass store on the timeout edge wins
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, F_NONE, 0, 0, 0, 0));
    for (int unsigned k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 0, 0, 0, k * 32'h101, k * 4, F_NONE, 0, k, 0, 0));
    vecs.push_back(mk(0, 1, 100, 25, 32'h33, 32'h20, F_PASS, 0, 8, 0, 0));

    m_hash = '0;
    m_live = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) begin
        m_hash = '0;
        m_live = 1'b1;
      end else if (m_live) begin
        m_hash = ref_hash(m_hash, v.ins, v.pc, v.we, v.dat);
      end
      if (!v.rst) m_live = m_live && !v.flags[3];
      drive(v.rst, v.we, v.adr, v.dat, v.ins, v.pc);
      chk($sformatf("v%0d flags", i), {28'd0, a_done, a_pass, a_fail, a_tout}, {28'd0, v.flags});
      chk($sformatf("v%0d store_count", i), {16'd0, a_sc}, {16'd0, v.sc});
      chk($sformatf("v%0d cycle_count", i), a_cc, v.cc);
      chk($sformatf("v%0d fail_adr", i), a_fa, v.fa);
      chk($sformatf("v%0d fail_data", i), a_fd, v.fd);
      chk($sformatf("v%0d hash", i), a_hash, m_hash);
      if (i == 11) chk("hash_const", a_hash, 32'h00A00226);
    end

    // Store-count saturation on the long-timeout instance
    drive(1, 0, 0, 0, 0, 0);
    chk("sat reset count", {16'd0, b_sc}, 32'd0);
    for (int unsigned k = 1; k <= 70000; k++) begin
      drive(0, 1, 96, k, 0, 0);
      if (k == 65534) chk("sat count 65534", {16'd0, b_sc}, 32'h0000FFFE);
      if (k == 65536) chk("sat count 65536", {16'd0, b_sc}, 32'h0000FFFF);
    end
    chk("sat count final", {16'd0, b_sc}, 32'h0000FFFF);
    chk("sat flags", {28'd0, b_done, b_pass, b_fail, b_tout}, 32'd0);
    chk("sat cycle_count", b_cc, 32'd70000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
# store_monitor

Self-checking monitor on the data-memory write bus of the multi-cycle RISC-V system. It samples `MemWrite`/`DataAdr`/`WriteData` and the datapath `Instr`/`PC` each clock, and accumulates the 32-bit execution signature hash. It classifies every store against pass/scratch addresses and latches a sticky pass/fail/timeout verdict. It sits beside the processor and memory wrapper and is synthesizable, so the same check runs in simulation and on an FPGA.

## Interface
- `PASS_ADR`, 32'd100, store address that ends the run
- `PASS_DATA`, 32'd25, data that, stored to PASS_ADR, means success
- `SCRATCH_ADR`, 32'd96, only other address stores may target without failing
- `TIMEOUT`, 32'd10000, RUN cycles allowed before a timeout verdict; legal range ≥1
- `clk` in 1 system clock, all state updates on rising edge
- `reset` in 1 synchronous, active-high reset
- `MemWrite` in 1 store strobe from processor
- `DataAdr` in 32 store address
- `WriteData` in 32 store data
- `Instr` in 32 current instruction register of datapath
- `PC` in 32 current PC of datapath
- `done` out 1 verdict reached (state ≠ RUN)
- `pass` out 1 sticky success flag
- `fail` out 1 sticky illegal-store flag
- `timeout` out 1 sticky timeout flag
- `hash` out 32 signature register
- `store_count` out 16 accepted scratch stores, saturating
- `cycle_count` out 32 RUN cycles elapsed
- `fail_adr` out 32 address of the failing store
- `fail_data` out 32 data of the failing store

## Operation
- FSM states: RUN, PASS, FAIL, TOUT. Reset → RUN. PASS/FAIL/TOUT are terminal and left only by reset.
- Outputs are registered. `pass`/`fail`/`timeout` are a one-hot decode of PASS/FAIL/TOUT; all are 0 in RUN. `done` is their OR.
- In RUN, each edge applies the following, in priority order:
  1. If `MemWrite` && `DataAdr`==PASS_ADR && `WriteData`==PASS_DATA → PASS.
  2. Else if `MemWrite` && `DataAdr`≠SCRATCH_ADR → FAIL, capturing `fail_adr`←`DataAdr` and `fail_data`←`WriteData`. This includes a store to PASS_ADR with wrong data.
  3. Else if `MemWrite` (scratch store) → `store_count` += 1, saturating at 16'hFFFF.
  4. If no rule 1/2 transition fired and `cycle_count`==TIMEOUT−1 → TOUT. A terminating store wins over a simultaneous timeout.
- `cycle_count` increments on every RUN edge, including the terminating edge, then freezes.
- Hash update, on every RUN edge including the terminating edge:
  - h = `hash` ^ `Instr` ^ `PC` ^ (`MemWrite` ? `WriteData` : 0)
  - `hash` ← {h[30:0], h[9]^h[29]^h[30]^h[31]}
- `hash` is frozen in terminal states.
- All arithmetic is unsigned. Comparisons are full 32-bit equality, with no byte-lane masking.

## Timing
- Reset values: state RUN; `done`, `pass`, `fail`, `timeout` = 0; `hash`, `store_count`, `cycle_count`, `fail_adr`, `fail_data` = 0.
- Reset asserted mid-run or in a terminal state clears everything on the next edge. Reset has priority over any store sampled on that edge.
- While `reset` is high, no hash, count or verdict update occurs.
- Verdict latency is 1 cycle: the flags are high immediately after the edge that samples the qualifying store.
- Timeout: with no stores and `reset` deasserted before edge 1, `timeout` rises after edge TIMEOUT, and `cycle_count` reads TIMEOUT.
- Inputs after a verdict are ignored, including further stores, which do not change `fail_adr`.
- There is no handshake: a store is exactly one cycle of `MemWrite`=1. N consecutive high cycles count as N stores.

## Test plan
- Reset, then one store (96, 7), then store (100, 25), with `Instr`=`PC`=0 → `store_count`=1, `pass`=1 one cycle later, `fail`=`timeout`=0. `hash` must equal the bench's reference model over those cycles.
- Store (100, 24) → `fail`=1, `fail_adr`=100, `fail_data`=24, `pass`=0. A later store (100, 25) leaves `fail`=1 and `pass`=0.
- Store (104, 0xDEADBEEF) → `fail`=1, `fail_adr`=104, `fail_data`=0xDEADBEEF.
- TIMEOUT=8, no stores → `timeout`=1 after the 8th edge, `cycle_count`=8. With TIMEOUT=8, store (100, 25) on the 8th edge → `pass`=1, `timeout`=0.
- `Instr`=0x00500113, `PC`=0 for one cycle from hash 0 → `hash`=0x00A00226. Assert `reset` mid-run → every output returns to 0 on the next edge.
- 70000 consecutive scratch stores with TIMEOUT=100000 → `store_count` saturates at 0xFFFF, and no verdict is reached.
